// File: rtl/ctrl_datapath.sv
// ctrl_datapath: four-register datapath driven one control word per clock.
// Holds R0..R3, an ALU with carry/overflow, a registered result output with a
// one-cycle valid pulse, a status-flag register and a saturating counter of
// register-load cycles.
module ctrl_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       ce,
    input  logic [2:0]       w,
    input  logic [2:0]       s,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] op_count
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    // ALU operation codes
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_INC  = 3'b111;

    // Write-back source codes
    localparam logic [1:0] WB_DIN = 2'b00;
    localparam logic [1:0] WB_F   = 2'b01;
    localparam logic [1:0] WB_SHR = 2'b10;
    localparam logic [1:0] WB_SHL = 2'b11;

    logic [3:0][WIDTH-1:0] r_q;
    logic [3:0][WIDTH-1:0] r_d;
    logic [WIDTH-1:0]      dout_q;
    logic [WIDTH-1:0]      dout_d;
    logic                  dout_valid_q;
    logic                  dout_valid_d;
    logic [3:0]            flags_q;
    logic [3:0]            flags_d;
    logic [CNT_W-1:0]      op_count_q;
    logic [CNT_W-1:0]      op_count_d;

    logic [WIDTH-1:0]      opnd_a;
    logic [WIDTH-1:0]      opnd_b;
    logic [WIDTH:0]        sum_ext;
    logic [WIDTH-1:0]      alu_f;
    logic                  alu_c;
    logic                  alu_v;
    logic [WIDTH-1:0]      wb_data;

    // Operand selection: A is always R0, B picks R2 or R1
    always_comb begin
        opnd_a = r_q[0];
        opnd_b = w[0] ? r_q[2] : r_q[1];
    end

    // ALU: result plus carry/overflow, only arithmetic ops produce c and V
    always_comb begin
        sum_ext = '0;
        alu_f   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s)
            OP_PASS: alu_f = opnd_a;
            OP_SUB: begin
                // c=1 means no borrow, from the two's-complement formulation
                sum_ext = {1'b0, opnd_a} + {1'b0, ~opnd_b} + ONE_EXT;
                alu_f   = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (opnd_a[MSB] ^ opnd_b[MSB]) & (alu_f[MSB] ^ opnd_a[MSB]);
            end
            OP_ADD: begin
                sum_ext = {1'b0, opnd_a} + {1'b0, opnd_b};
                alu_f   = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = ~(opnd_a[MSB] ^ opnd_b[MSB]) & (alu_f[MSB] ^ opnd_a[MSB]);
            end
            OP_AND:  alu_f = opnd_a & opnd_b;
            OP_OR:   alu_f = opnd_a | opnd_b;
            OP_XOR:  alu_f = opnd_a ^ opnd_b;
            OP_NOT:  alu_f = ~opnd_a;
            OP_INC: begin
                // Incrementing a positive value can only overflow into the sign bit
                sum_ext = {1'b0, opnd_a} + ONE_EXT;
                alu_f   = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = ~opnd_a[MSB] & alu_f[MSB];
            end
            default: alu_f = opnd_a;
        endcase
    end

    // Write-back source mux; shifts are logical with zero fill
    always_comb begin
        wb_data = din;
        case (sel)
            WB_DIN: wb_data = din;
            WB_F:   wb_data = alu_f;
            WB_SHR: wb_data = {1'b0, alu_f[MSB:1]};
            WB_SHL: wb_data = {alu_f[MSB-1:0], 1'b0};
            default: wb_data = din;
        endcase
    end

    // Per-register next state: clear wins, otherwise load D when enabled
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg_next
            assign r_d[gi] = clr    ? '0 :
                             ce[gi] ? wb_data : r_q[gi];
        end
    endgenerate

    // Output, flag and counter next state
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        flags_d      = flags_q;
        op_count_d   = op_count_q;
        if (clr) begin
            flags_d    = '0;
            op_count_d = '0;
        end else begin
            if (w[2]) begin
                dout_d       = alu_f;
                dout_valid_d = 1'b1;
            end
            if (w[1]) begin
                flags_d = {alu_f[MSB], (alu_f == '0), alu_c, alu_v};
            end
            // Saturate at all-ones instead of wrapping
            if ((ce != 4'b0000) && (op_count_q != {CNT_W{1'b1}})) begin
                op_count_d = op_count_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset; reset discards the control word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            flags_q      <= '0;
            op_count_q   <= '0;
        end else begin
            r_q          <= r_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            flags_q      <= flags_d;
            op_count_q   <= op_count_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign flags      = flags_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_ctrl_datapath.sv
// Scoreboard bench for ctrl_datapath: the driver computes expected results with
// an arithmetic reference model and queues them; a monitor compares on negedge.
module tb_ctrl_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] ce;
    logic [2:0] w;
    logic [2:0] s;
    logic [1:0] sel;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic [3:0] flags;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dout;
        logic       dv;
        logic [3:0] flags;
        logic [7:0] cnt;
    } status_t;

    status_t    exp_q[$];
    logic [7:0] dq[$];
    status_t    e;
    logic [7:0] ed;

    // Reference model state
    int  mr[4];
    int  m_dout;
    bit  m_dv;
    int  m_flags;
    int  m_cnt;

    ctrl_datapath #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ce(ce), .w(w), .s(s), .sel(sel),
        .din(din), .dout(dout), .dout_valid(dout_valid), .flags(flags),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Apply one control word for one clock and queue the expected result
    task automatic drive(input bit rst_i, input bit clr_i, input logic [3:0] ce_i,
                         input logic [2:0] w_i, input logic [2:0] s_i,
                         input logic [1:0] sel_i, input logic [7:0] din_i);
        int a, b, f, d, sr;
        bit c, v;
        status_t st;
        rst = rst_i; clr = clr_i; ce = ce_i; w = w_i; s = s_i; sel = sel_i; din = din_i;
        a = mr[0];
        b = w_i[0] ? mr[2] : mr[1];
        c = 1'b0; v = 1'b0; f = a;
        case (s_i)
            3'd0: f = a;
            3'd1: begin
                f = (a - b + 256) % 256; c = (a >= b);
                sr = to_signed8(a) - to_signed8(b); v = (sr < -128) || (sr > 127);
            end
            3'd2: begin
                f = (a + b) % 256; c = (a + b) > 255;
                sr = to_signed8(a) + to_signed8(b); v = (sr < -128) || (sr > 127);
            end
            3'd3: f = a & b;
            3'd4: f = a | b;
            3'd5: f = a ^ b;
            3'd6: f = 255 - a;
            default: begin
                f = (a + 1) % 256; c = (a == 255); v = (a == 127);
            end
        endcase
        case (sel_i)
            2'd0: d = din_i;
            2'd1: d = f;
            2'd2: d = f / 2;
            default: d = (f * 2) % 256;
        endcase
        if (rst_i) begin
            for (int i = 0; i < 4; i++) mr[i] = 0;
            m_dout = 0; m_dv = 0; m_flags = 0; m_cnt = 0;
        end else if (clr_i) begin
            for (int i = 0; i < 4; i++) mr[i] = 0;
            m_dv = 0; m_flags = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (ce_i[i]) mr[i] = d;
            if (ce_i != 4'b0000 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_dv = w_i[2];
            if (w_i[2]) m_dout = f;
            if (w_i[1]) m_flags = ((f >= 128) ? 8 : 0) + ((f == 0) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
        end
        @(posedge clk);
        #1;
        st.dout = m_dout[7:0]; st.dv = m_dv; st.flags = m_flags[3:0]; st.cnt = m_cnt[7:0];
        exp_q.push_back(st);
        if (m_dv) dq.push_back(m_dout[7:0]);
    endtask

    // Monitor: registered outputs are compared half a cycle after each edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dout !== e.dout) begin
                errors++; $display("FAIL dout got=%h exp=%h t=%0t", dout, e.dout, $time);
            end
            checks++;
            if (dout_valid !== e.dv) begin
                errors++; $display("FAIL dout_valid got=%b exp=%b t=%0t", dout_valid, e.dv, $time);
            end
            checks++;
            if (flags !== e.flags) begin
                errors++; $display("FAIL flags got=%b exp=%b t=%0t", flags, e.flags, $time);
            end
            checks++;
            if (op_count !== e.cnt) begin
                errors++; $display("FAIL op_count got=%0d exp=%0d t=%0t", op_count, e.cnt, $time);
            end
        end
        if (dout_valid === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++; $display("FAIL result_pulse unexpected dout=%h t=%0t", dout, $time);
            end else begin
                ed = dq.pop_front();
                if (dout !== ed) begin
                    errors++; $display("FAIL result got=%h exp=%h t=%0t", dout, ed, $time);
                end else begin
                    $display("result dout=%h flags=%b t=%0t", dout, flags, $time);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) mr[i] = 0;
        m_dout = 0; m_dv = 0; m_flags = 0; m_cnt = 0;
        rst = 1'b1; clr = 1'b0; ce = '0; w = '0; s = '0; sel = '0; din = '0;
        #2;
        // Reset state
        drive(1, 0, 4'b0000, 3'b000, 3'b000, 2'b00, 8'h00);
        drive(1, 0, 4'b0000, 3'b000, 3'b000, 2'b00, 8'h00);
        // Load and subtract
        drive(0, 0, 4'b1111, 3'b000, 3'b000, 2'b00, 8'h25);
        drive(0, 0, 4'b0010, 3'b000, 3'b000, 2'b00, 8'h0C);
        drive(0, 0, 4'b0000, 3'b110, 3'b001, 2'b00, 8'h00);
        // Shift write-back
        drive(0, 0, 4'b0001, 3'b000, 3'b001, 2'b11, 8'h00);
        drive(0, 0, 4'b0001, 3'b100, 3'b001, 2'b10, 8'h00);
        drive(0, 0, 4'b0000, 3'b100, 3'b000, 2'b00, 8'h00);
        // Zero flag on equal subtract, overflow on 0x7F+1
        drive(0, 0, 4'b0011, 3'b000, 3'b000, 2'b00, 8'h40);
        drive(0, 0, 4'b0000, 3'b010, 3'b001, 2'b00, 8'h00);
        drive(0, 0, 4'b0001, 3'b000, 3'b000, 2'b00, 8'h7F);
        drive(0, 0, 4'b0010, 3'b000, 3'b000, 2'b00, 8'h01);
        drive(0, 0, 4'b0000, 3'b110, 3'b010, 2'b00, 8'h00);
        drive(0, 0, 4'b0000, 3'b110, 3'b111, 2'b00, 8'h00);
        // Operand-B select
        drive(0, 0, 4'b0001, 3'b000, 3'b000, 2'b00, 8'h10);
        drive(0, 0, 4'b0010, 3'b000, 3'b000, 2'b00, 8'h01);
        drive(0, 0, 4'b0100, 3'b000, 3'b000, 2'b00, 8'h05);
        drive(0, 0, 4'b0000, 3'b101, 3'b010, 2'b00, 8'h00);
        drive(0, 0, 4'b0000, 3'b100, 3'b010, 2'b00, 8'h00);
        // Clear beats load; dout holds
        drive(0, 1, 4'b1111, 3'b111, 3'b010, 2'b00, 8'hFF);
        drive(0, 0, 4'b0000, 3'b000, 3'b000, 2'b00, 8'h00);
        // Reset mid-sequence discards the control word
        drive(0, 0, 4'b1111, 3'b000, 3'b000, 2'b00, 8'hA5);
        drive(1, 0, 4'b1111, 3'b111, 3'b010, 2'b01, 8'h3C);
        drive(0, 0, 4'b0000, 3'b110, 3'b000, 2'b00, 8'h00);
        // Saturating counter
        for (int i = 0; i < 300; i++) drive(0, 0, 4'b0001, 3'b000, 3'b000, 2'b00, 8'(i));
        drive(0, 1, 4'b0000, 3'b000, 3'b000, 2'b00, 8'h00);
        // Randomized control words
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  4'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 8'($urandom));
        end
        drive(0, 0, 4'b0000, 3'b000, 3'b000, 2'b00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain pending_status=%0d pending_results=%0d exp=0", exp_q.size(), dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
